// File: rtl/rolha_transfer_scheduler.sv
// Cork buffer transfer scheduler: arbitrates operator loads into the secondary
// buffer and automatic refills into the principal buffer, one cork per clock.
module rolha_transfer_scheduler #(
  parameter int unsigned SEC_MAX      = 99,
  parameter int unsigned PRI_MAX      = 31,
  parameter int unsigned TRANSFER_QTY = 20,
  parameter int unsigned PRI_MIN      = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       enable,
  input  logic       op_req,
  input  logic [6:0] op_qty,
  input  logic       vedacao,
  output logic [6:0] sec_count,
  output logic [4:0] pri_count,
  output logic [1:0] state,
  output logic       busy,
  output logic       op_ack,
  output logic       op_nack,
  output logic       ro
);

  localparam int unsigned SEC_W = 7;
  localparam int unsigned PRI_W = 5;

  localparam logic [SEC_W-1:0] SEC_MAX_C  = SEC_W'(SEC_MAX);
  localparam logic [SEC_W-1:0] XFER_QTY_C = SEC_W'(TRANSFER_QTY);
  localparam logic [PRI_W-1:0] PRI_MAX_C  = PRI_W'(PRI_MAX);
  localparam logic [PRI_W-1:0] PRI_MIN_C  = PRI_W'(PRI_MIN);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_LOAD_OP = 2'b01,
    ST_XFER    = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic [SEC_W-1:0] op_qty_q, op_qty_d;
  logic             op_pending_q, op_pending_d;
  logic             op_ack_d, op_nack_d;
  logic [SEC_W-1:0] sec_d;
  logic [PRI_W-1:0] pri_d;

  logic             refill_req;
  logic [SEC_W:0]   load_sum;
  logic             sec_inc, sec_dec, pri_inc;
  logic             pri_up, pri_dn;

  assign refill_req = (pri_count < PRI_MIN_C) && (sec_count >= XFER_QTY_C);
  assign load_sum   = {1'b0, sec_count} + {1'b0, op_qty_q};

  assign state = state_q;
  assign busy  = (state_q != ST_IDLE);
  assign ro    = (pri_count == '0);

  // Next-state, request latch and arbitration
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    op_pending_d = op_pending_q;
    op_qty_d     = op_qty_q;
    op_ack_d     = 1'b0;
    op_nack_d    = 1'b0;
    sec_inc      = 1'b0;
    sec_dec      = 1'b0;
    pri_inc      = 1'b0;

    // A request is held even while the line is stopped; a second one is dropped
    if (op_req) begin
      if (!op_pending_q && (state_q != ST_LOAD_OP)) begin
        op_pending_d = 1'b1;
        op_qty_d     = op_qty;
      end else begin
        op_nack_d = 1'b1;
      end
    end

    if (enable) begin
      unique case (state_q)
        ST_IDLE: begin
          if (refill_req) begin
            state_d = ST_XFER;
            rem_d   = XFER_QTY_C;
          end else if (op_pending_q) begin
            op_pending_d = 1'b0;
            if ((op_qty_q == '0) || (load_sum > {1'b0, SEC_MAX_C})) begin
              op_nack_d = 1'b1;
            end else begin
              state_d = ST_LOAD_OP;
              rem_d   = op_qty_q;
            end
          end
        end
        ST_LOAD_OP: begin
          sec_inc = 1'b1;
          if (rem_q <= SEC_W'(1)) begin
            rem_d    = '0;
            state_d  = ST_IDLE;
            op_ack_d = 1'b1;
          end else begin
            rem_d = rem_q - SEC_W'(1);
          end
        end
        ST_XFER: begin
          sec_dec = 1'b1;
          pri_inc = 1'b1;
          if (rem_q <= SEC_W'(1)) begin
            rem_d   = '0;
            state_d = ST_IDLE;
          end else begin
            rem_d = rem_q - SEC_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Buffer counters with saturation guards; sealing consumption runs alongside transfers
  always_comb begin
    sec_d  = sec_count;
    pri_d  = pri_count;
    pri_up = pri_inc && (pri_count < PRI_MAX_C);
    pri_dn = enable && vedacao && (pri_count != '0);

    if (sec_inc && (sec_count < SEC_MAX_C)) begin
      sec_d = sec_count + SEC_W'(1);
    end else if (sec_dec && (sec_count != '0)) begin
      sec_d = sec_count - SEC_W'(1);
    end

    if (pri_up && !pri_dn) begin
      pri_d = pri_count + PRI_W'(1);
    end else if (pri_dn && !pri_up) begin
      pri_d = pri_count - PRI_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      op_qty_q     <= '0;
      op_pending_q <= 1'b0;
      op_ack       <= 1'b0;
      op_nack      <= 1'b0;
      sec_count    <= '0;
      pri_count    <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      op_qty_q     <= op_qty_d;
      op_pending_q <= op_pending_d;
      op_ack       <= op_ack_d;
      op_nack      <= op_nack_d;
      sec_count    <= sec_d;
      pri_count    <= pri_d;
    end
  end

endmodule

// File: tb/tb_rolha_transfer_scheduler.sv
// Self-checking bench for rolha_transfer_scheduler: load table, refill sequences,
// freeze, floor and async clear, with an ack/nack scoreboard.
module tb_rolha_transfer_scheduler;

  logic       clk;
  logic       clr;
  logic       enable;
  logic       op_req;
  logic [6:0] op_qty;
  logic       vedacao;
  logic [6:0] sec_count;
  logic [4:0] pri_count;
  logic [1:0] state;
  logic       busy;
  logic       op_ack;
  logic       op_nack;
  logic       ro;

  int checks   = 0;
  int failures = 0;

  // Expected sec_count when each ack / nack appears (-1: not checked)
  int ack_q[$];
  int nack_q[$];
  int mon_exp;

  typedef struct {
    logic [6:0] qty;
    logic       exp_ack;
    logic [6:0] exp_sec;
  } load_vec_t;

  load_vec_t vecs[5];

  rolha_transfer_scheduler dut (
    .clk      (clk),
    .clr      (clr),
    .enable   (enable),
    .op_req   (op_req),
    .op_qty   (op_qty),
    .vedacao  (vedacao),
    .sec_count(sec_count),
    .pri_count(pri_count),
    .state    (state),
    .busy     (busy),
    .op_ack   (op_ack),
    .op_nack  (op_nack),
    .ro       (ro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every ack/nack must match an outstanding expectation
  always @(negedge clk) begin
    if (clr === 1'b1) begin
      if (op_ack === 1'b1) begin
        if (ack_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: op_ack=1 with none outstanding, sec=%0d", sec_count);
        end else begin
          mon_exp = ack_q.pop_front();
          check("ack_sec", int'(sec_count), mon_exp);
        end
      end
      if (op_nack === 1'b1) begin
        if (nack_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_nack: op_nack=1 with none outstanding, sec=%0d", sec_count);
        end else begin
          mon_exp = nack_q.pop_front();
          check("nack_not_ack", int'(op_ack), 0);
          if (mon_exp >= 0) check("nack_sec", int'(sec_count), mon_exp);
        end
      end
    end
  end

  // Issue one operator load from IDLE and wait (bounded) for its response
  task automatic do_load(input logic [6:0] qty, input logic exp_ack, input logic [6:0] exp_sec);
    int  n;
    bit  done;
    if (exp_ack) ack_q.push_back(int'(exp_sec));
    else         nack_q.push_back(int'(exp_sec));
    @(negedge clk);
    op_req = 1'b1;
    op_qty = qty;
    @(negedge clk);
    op_req = 1'b0;
    done = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      if (op_ack || op_nack) done = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("load_resp_seen", int'(done), 1);
    check("load_resp_kind", int'(op_ack), int'(exp_ack));
  endtask

  task automatic pulse_ved(input int n);
    vedacao = 1'b1;
    repeat (n) @(negedge clk);
    vedacao = 1'b0;
  endtask

  initial begin
    int n;

    vecs[0] = '{qty: 7'd85,  exp_ack: 1'b1, exp_sec: 7'd95};
    vecs[1] = '{qty: 7'd5,   exp_ack: 1'b0, exp_sec: 7'd95};
    vecs[2] = '{qty: 7'd4,   exp_ack: 1'b1, exp_sec: 7'd99};
    vecs[3] = '{qty: 7'd0,   exp_ack: 1'b0, exp_sec: 7'd99};
    vecs[4] = '{qty: 7'd127, exp_ack: 1'b0, exp_sec: 7'd99};

    clr = 1'b0;
    enable = 1'b1;
    op_req = 1'b0;
    op_qty = '0;
    vedacao = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sec", int'(sec_count), 0);
    check("rst_pri", int'(pri_count), 0);
    check("rst_state", int'(state), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ack", int'(op_ack), 0);
    check("rst_nack", int'(op_nack), 0);
    check("rst_ro", int'(ro), 1);
    clr = 1'b1;

    // Sealing with an empty principal buffer stays at zero
    pulse_ved(3);
    check("floor_pri", int'(pri_count), 0);
    check("floor_ro", int'(ro), 1);

    // First load of 10: one increment per edge, ack 11 edges after the request
    ack_q.push_back(10);
    op_req = 1'b1;
    op_qty = 7'd10;
    @(negedge clk);
    op_req = 1'b0;
    check("a_pending_idle", int'(state), 0);
    @(negedge clk);
    check("a_granted", int'(state), 1);
    check("a_sec0", int'(sec_count), 0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("a_sec_step", int'(sec_count), i);
      check("a_ack_timing", int'(op_ack), (i == 10) ? 1 : 0);
    end
    check("a_back_idle", int'(state), 0);
    @(negedge clk);
    check("a_ack_single", int'(op_ack), 0);

    // Reach sec=30 with pri=0: a refill starts straight after the ack
    do_load(7'd20, 1'b1, 7'd30);
    @(negedge clk);
    check("b_xfer_start", int'(state), 2);
    check("b_busy", int'(busy), 1);
    ack_q.push_back(15);
    nack_q.push_back(-1);
    for (int k = 1; k <= 20; k++) begin
      vedacao = (k == 3 || k == 7 || k == 11);
      if (k == 5) begin op_req = 1'b1; op_qty = 7'd5; end
      if (k == 9) begin op_req = 1'b1; op_qty = 7'd3; end
      @(negedge clk);
      vedacao = 1'b0;
      op_req = 1'b0;
      check("b_sec_step", int'(sec_count), 30 - k);
      check("b_state", int'(state), (k < 20) ? 2 : 0);
      check("b_no_ack", int'(op_ack), 0);
    end
    check("b_pri_end", int'(pri_count), 17);
    n = 0;
    while (!op_ack && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("b_deferred_ack", int'(op_ack), 1);
    check("b_sec_loaded", int'(sec_count), 15);
    check("b_pri_after", int'(pri_count), 17);

    // Drain to pri=4 without enough stock for a refill, then refill from sec=30
    pulse_ved(13);
    check("c_pri4", int'(pri_count), 4);
    check("c_ro0", int'(ro), 0);
    @(negedge clk);
    check("c_no_refill", int'(state), 0);
    do_load(7'd15, 1'b1, 7'd30);
    @(negedge clk);
    check("c_xfer", int'(state), 2);
    check("c_busy", int'(busy), 1);
    repeat (20) @(negedge clk);
    check("c_idle", int'(state), 0);
    check("c_sec", int'(sec_count), 10);
    check("c_pri", int'(pri_count), 24);

    // Capacity boundaries
    for (int i = 0; i < 5; i++) begin
      do_load(vecs[i].qty, vecs[i].exp_ack, vecs[i].exp_sec);
      check("tbl_sec", int'(sec_count), int'(vecs[i].exp_sec));
      check("tbl_state", int'(state), 0);
    end

    // Refill to sec=79/pri=24, then freeze a load with three corks left
    pulse_ved(20);
    check("d_pri4", int'(pri_count), 4);
    repeat (21) @(negedge clk);
    check("d_idle", int'(state), 0);
    check("d_sec", int'(sec_count), 79);
    check("d_pri", int'(pri_count), 24);
    ack_q.push_back(89);
    op_req = 1'b1;
    op_qty = 7'd10;
    @(negedge clk);
    op_req = 1'b0;
    @(negedge clk);
    check("d_granted", int'(state), 1);
    repeat (7) @(negedge clk);
    check("d_sec86", int'(sec_count), 86);
    enable = 1'b0;
    vedacao = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("d_frz_sec", int'(sec_count), 86);
      check("d_frz_pri", int'(pri_count), 24);
      check("d_frz_state", int'(state), 1);
    end
    enable = 1'b1;
    vedacao = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      check("d_resume_sec", int'(sec_count), 86 + j);
    end
    check("d_ack", int'(op_ack), 1);
    check("d_idle2", int'(state), 0);
    @(negedge clk);
    check("d_ack_single", int'(op_ack), 0);

    // Refill beats a pending load; async clear mid-transfer drops both
    vedacao = 1'b1;
    repeat (19) @(negedge clk);
    op_req = 1'b1;
    op_qty = 7'd1;
    @(negedge clk);
    vedacao = 1'b0;
    op_req = 1'b0;
    check("f_pri4", int'(pri_count), 4);
    @(negedge clk);
    check("f_refill_prio", int'(state), 2);
    repeat (4) @(negedge clk);
    check("f_sec_mid", int'(sec_count), 85);
    check("f_pri_mid", int'(pri_count), 8);
    #2 clr = 1'b0;
    #1;
    check("f_clr_sec", int'(sec_count), 0);
    check("f_clr_pri", int'(pri_count), 0);
    check("f_clr_state", int'(state), 0);
    check("f_clr_busy", int'(busy), 0);
    check("f_clr_ack", int'(op_ack), 0);
    check("f_clr_nack", int'(op_nack), 0);
    check("f_clr_ro", int'(ro), 1);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    repeat (30) @(negedge clk);
    check("f_post_state", int'(state), 0);
    check("f_post_sec", int'(sec_count), 0);

    check("sb_ack_empty", ack_q.size(), 0);
    check("sb_nack_empty", nack_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
